// File: rtl/sejf_pkg.sv
// -----------------------------------------------------------------------------
// sejf_pkg
// Shared types and helpers for the safe combination-lock controller.
//   state_t     : controller FSM states
//   mode_t      : whether the three-value sequence is a combination attempt
//                 or a reprogramming of the stored code
//   CODE_W      : width of one code value / dial position (0..31)
//   bcd_to_bin  : converts the two-digit BCD dial reading to binary
// -----------------------------------------------------------------------------
package sejf_pkg;

    localparam int CODE_W = 5;

    typedef enum logic [2:0] {
        ENTRY,
        CAPT,
        CLR,
        EVAL,
        OPEN,
        PROG,
        LOCKOUT
    } state_t;

    typedef enum logic {
        MODE_ENTRY,
        MODE_PROG
    } mode_t;

    // The dial never exceeds 31, so 5-bit arithmetic is exact for every
    // legal reading.
    function automatic logic [CODE_W-1:0] bcd_to_bin(input logic [3:0] bcd1,
                                                     input logic [3:0] bcd0);
        return ({1'b0, bcd1} * 5'd10) + {1'b0, bcd0};
    endfunction

endpackage

// File: rtl/sejf_lock_timer.sv
// -----------------------------------------------------------------------------
// sejf_lock_timer
// Loadable down-counter used to time the alarm lockout.
//   clk        : clock
//   rst        : asynchronous active-high reset (counter cleared)
//   i_load     : load i_load_val (has priority over counting)
//   i_load_val : value to load
//   i_en       : count down by one per cycle while non-zero
//   o_done     : counter is at zero
// -----------------------------------------------------------------------------
module sejf_lock_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/sejf_ctrl.sv
// -----------------------------------------------------------------------------
// sejf_ctrl
// Combination-lock controller. Converts step/enter button pulses into dial
// counter moves, captures three dial values and compares them with the stored
// code, opens the lock, flags wrong entries and locks the user out after
// MAX_FAIL consecutive failures. While open, the code can be reprogrammed.
//   clk, rst      : clock, asynchronous active-high reset
//   step, dir     : move dial one position (dir 1 = up)
//   enter         : accept current dial value
//   close         : relock while open
//   prog          : with enter while open, start reprogramming
//   bcd1, bcd0    : dial counter tens / units digits
//   up            : dial counter direction
//   cnten1        : dial step hold, active-low (one-cycle low per step)
//   cnten2        : dial freeze, active-high (during lockout)
//   clrCount      : dial clear pulse
//   unlocked      : lock open
//   err           : one-cycle pulse on a wrong combination
//   alarm         : high for the whole lockout
//   idx           : index of the value currently being entered
// All outputs are registered.
// -----------------------------------------------------------------------------
module sejf_ctrl
    import sejf_pkg::*;
#(
    parameter logic [CODE_W-1:0] CODE0    = 5'd12,
    parameter logic [CODE_W-1:0] CODE1    = 5'd7,
    parameter logic [CODE_W-1:0] CODE2    = 5'd25,
    parameter int                MAX_FAIL = 3,
    parameter int                LOCK_CYC = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    input  logic       dir,
    input  logic       enter,
    input  logic       close,
    input  logic       prog,
    input  logic [3:0] bcd0,
    input  logic [3:0] bcd1,
    output logic       up,
    output logic       cnten1,
    output logic       cnten2,
    output logic       clrCount,
    output logic       unlocked,
    output logic       err,
    output logic       alarm,
    output logic [1:0] idx
);

    localparam int         TMR_W     = $clog2(LOCK_CYC);
    localparam logic [2:0] FAIL_LAST = 3'(MAX_FAIL - 1);

    state_t            r_state;
    mode_t             r_mode;
    logic [1:0]        r_idx;
    logic [2:0]        r_fail_cnt;
    logic              r_mismatch;
    logic [CODE_W-1:0] r_code [3];

    logic r_up;
    logic r_cnten1;
    logic r_cnten2;
    logic r_clr;
    logic r_unlocked;
    logic r_err;
    logic r_alarm;

    logic [CODE_W-1:0] w_dial;
    logic [CODE_W-1:0] w_code_sel;
    logic              w_dial_state;
    logic              w_enter_ok;
    logic              w_step_ok;
    logic              w_timer_load;
    logic              w_timer_en;
    logic              w_timer_done;

    assign w_dial = bcd_to_bin(bcd1, bcd0);

    always_comb begin
        w_code_sel = r_code[0];
        case (r_idx)
            2'd1:    w_code_sel = r_code[1];
            2'd2:    w_code_sel = r_code[2];
            default: w_code_sel = r_code[0];
        endcase
    end

    // States in which the user may operate the dial.
    assign w_dial_state = (r_state == ENTRY) || (r_state == OPEN) || (r_state == PROG);

    // close beats enter while open; enter without prog is ignored there.
    assign w_enter_ok = enter && ((r_state == ENTRY) || (r_state == PROG) ||
                                  ((r_state == OPEN) && prog && !close));

    // A step coinciding with an accepted enter is dropped so the captured
    // value is the one the user saw when pressing enter.
    assign w_step_ok = step && w_dial_state && !w_enter_ok;

    // Load on the EVAL cycle that decides lockout; count while locked out.
    assign w_timer_load = (r_state == EVAL) && r_mismatch && (r_fail_cnt == FAIL_LAST);
    assign w_timer_en   = (r_state == LOCKOUT);

    sejf_lock_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_timer_load),
        .i_load_val (TMR_W'(LOCK_CYC - 1)),
        .i_en       (w_timer_en),
        .o_done     (w_timer_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ENTRY;
            r_mode     <= MODE_ENTRY;
            r_idx      <= 2'd0;
            r_fail_cnt <= 3'd0;
            r_mismatch <= 1'b0;
            r_code[0]  <= CODE0;
            r_code[1]  <= CODE1;
            r_code[2]  <= CODE2;
            r_up       <= 1'b1;
            r_cnten1   <= 1'b1;
            r_cnten2   <= 1'b0;
            r_clr      <= 1'b0;
            r_unlocked <= 1'b0;
            r_err      <= 1'b0;
            r_alarm    <= 1'b0;
        end else begin
            r_clr    <= 1'b0;
            r_err    <= 1'b0;
            // Outside the dial states w_step_ok is 0, so the hold is released
            // automatically in CAPT/CLR/EVAL/LOCKOUT; this also guarantees the
            // clear pulse never overlaps a step.
            r_cnten1 <= !w_step_ok;
            if (w_step_ok) begin
                r_up <= dir;
            end

            case (r_state)
                ENTRY: begin
                    if (w_enter_ok) begin
                        r_mode  <= MODE_ENTRY;
                        r_state <= CAPT;
                    end
                end

                OPEN: begin
                    if (close) begin
                        r_unlocked <= 1'b0;
                        r_state    <= ENTRY;
                    end else if (w_enter_ok) begin
                        r_mode  <= MODE_PROG;
                        r_state <= CAPT;
                    end
                end

                PROG: begin
                    if (w_enter_ok) begin
                        r_state <= CAPT;
                    end
                end

                CAPT: begin
                    if (r_mode == MODE_ENTRY) begin
                        r_mismatch <= r_mismatch | (w_dial != w_code_sel);
                    end else begin
                        for (int k = 0; k < 3; k++) begin
                            if (r_idx == 2'(k)) begin
                                r_code[k] <= w_dial;
                            end
                        end
                    end
                    r_clr   <= 1'b1;
                    r_state <= CLR;
                end

                CLR: begin
                    if (r_idx == 2'd2) begin
                        r_idx   <= 2'd0;
                        r_state <= (r_mode == MODE_PROG) ? OPEN : EVAL;
                    end else begin
                        r_idx   <= r_idx + 2'd1;
                        r_state <= (r_mode == MODE_PROG) ? PROG : ENTRY;
                    end
                end

                EVAL: begin
                    r_mismatch <= 1'b0;
                    if (!r_mismatch) begin
                        r_fail_cnt <= 3'd0;
                        r_unlocked <= 1'b1;
                        r_state    <= OPEN;
                    end else if (r_fail_cnt == FAIL_LAST) begin
                        r_alarm  <= 1'b1;
                        r_cnten2 <= 1'b1;
                        r_state  <= LOCKOUT;
                    end else begin
                        r_err      <= 1'b1;
                        r_fail_cnt <= r_fail_cnt + 3'd1;
                        r_state    <= ENTRY;
                    end
                end

                LOCKOUT: begin
                    if (w_timer_done) begin
                        r_clr      <= 1'b1;
                        r_fail_cnt <= 3'd0;
                        r_alarm    <= 1'b0;
                        r_cnten2   <= 1'b0;
                        r_state    <= ENTRY;
                    end
                end

                default: r_state <= ENTRY;
            endcase
        end
    end

    assign up       = r_up;
    assign cnten1   = r_cnten1;
    assign cnten2   = r_cnten2;
    assign clrCount = r_clr;
    assign unlocked = r_unlocked;
    assign err      = r_err;
    assign alarm    = r_alarm;
    assign idx      = r_idx;

endmodule

// File: tb/tb_sejf_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sejf_ctrl
// Self-checking bench for sejf_ctrl. Contains a model of the external BCD dial
// counter (00..31, wrapping) driven by the controller outputs, and an abstract
// model of the lock (stored code, failure count, open flag) that predicts the
// outcome of each three-value sequence.
// -----------------------------------------------------------------------------
module tb_sejf_ctrl;

    localparam logic [4:0] P_CODE0    = 5'd12;
    localparam logic [4:0] P_CODE1    = 5'd7;
    localparam logic [4:0] P_CODE2    = 5'd25;
    localparam int         P_MAX_FAIL = 3;
    localparam int         P_LOCK_CYC = 1000;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       step  = 1'b0;
    logic       dir   = 1'b0;
    logic       enter = 1'b0;
    logic       close = 1'b0;
    logic       prog  = 1'b0;
    logic [3:0] bcd0;
    logic [3:0] bcd1;
    logic       up;
    logic       cnten1;
    logic       cnten2;
    logic       clrCount;
    logic       unlocked;
    logic       err;
    logic       alarm;
    logic [1:0] idx;

    logic [4:0] dial;

    int n_cmp     = 0;
    int n_bad     = 0;
    int n_clr     = 0;
    int n_overlap = 0;

    int m_code [3];
    int m_fail;
    bit m_open;

    sejf_ctrl #(
        .CODE0    (P_CODE0),
        .CODE1    (P_CODE1),
        .CODE2    (P_CODE2),
        .MAX_FAIL (P_MAX_FAIL),
        .LOCK_CYC (P_LOCK_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .step     (step),
        .dir      (dir),
        .enter    (enter),
        .close    (close),
        .prog     (prog),
        .bcd0     (bcd0),
        .bcd1     (bcd1),
        .up       (up),
        .cnten1   (cnten1),
        .cnten2   (cnten2),
        .clrCount (clrCount),
        .unlocked (unlocked),
        .err      (err),
        .alarm    (alarm),
        .idx      (idx)
    );

    always #5 clk = ~clk;

    // External dial counter: counts only when both enables are 0.
    always @(posedge clk or posedge rst) begin
        if (rst)                     dial <= 5'd0;
        else if (clrCount)           dial <= 5'd0;
        else if (!cnten1 && !cnten2) dial <= up ? dial + 5'd1 : dial - 5'd1;
    end

    assign bcd1 = 4'(dial / 5'd10);
    assign bcd0 = 4'(dial % 5'd10);

    always @(negedge clk) begin
        if (clrCount === 1'b1) n_clr++;
        if (clrCount === 1'b1 && cnten1 === 1'b0) n_overlap++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic dial_to(input int target);
        int d_up;
        int n;
        bit go_up;
        d_up  = (target - int'(dial) + 32) % 32;
        go_up = 1'($urandom_range(0, 1));
        n     = (d_up == 0) ? 0 : (go_up ? d_up : 32 - d_up);
        for (int i = 0; i < n; i++) begin
            step = 1'b1;
            dir  = go_up;
            tick();
            step = 1'b0;
            if ($urandom_range(0, 3) == 0) tick();
        end
        tick();
        tick();
        check("dial_pos", 32'(dial), 32'(target));
    endtask

    // Dial to v and press enter; returns two cycles after the accepting edge.
    task automatic enter_value(input int v, input bit with_step);
        dial_to(v);
        if (with_step) begin
            step = 1'b1;
            dir  = 1'($urandom_range(0, 1));
        end
        enter = 1'b1;
        tick();
        enter = 1'b0;
        step  = 1'b0;
        check("no_step_on_enter", 32'(cnten1), 32'd1);
        tick();
        tick();
        check("dial_cleared", 32'(dial), 32'd0);
    endtask

    task automatic lockout_phase();
        int cnt;
        cnt = 0;
        while (alarm === 1'b1 && cnt <= P_LOCK_CYC + 5) begin
            if (cnt == 0) check("lock_cnten2", 32'(cnten2), 32'd1);
            cnt++;
            step  = 1'($urandom_range(0, 1));
            dir   = 1'($urandom_range(0, 1));
            enter = 1'($urandom_range(0, 1));
            tick();
        end
        step  = 1'b0;
        enter = 1'b0;
        check("lock_len", 32'(cnt), 32'(P_LOCK_CYC));
        check("lock_dial_frozen", 32'(dial), 32'd0);
        check("lock_exit_clr", 32'(clrCount), 32'd1);
        check("lock_exit_cnten2", 32'(cnten2), 32'd0);
        tick();
        check("lock_exit_dial", 32'(dial), 32'd0);
        $display("lockout lasted %0d cycles", cnt);
    endtask

    task automatic attempt(input int a0, input int a1, input int a2, input bit ws);
        int  c0;
        bit  ok;
        bit  exp_err;
        bit  exp_lock;
        c0 = n_clr;
        enter_value(a0, ws);
        check("idx_after_1", 32'(idx), 32'd1);
        enter_value(a1, ws);
        check("idx_after_2", 32'(idx), 32'd2);
        enter_value(a2, ws);
        check("pre_eval_unlocked", 32'(unlocked), 32'd0);
        check("pre_eval_err", 32'(err), 32'd0);
        ok       = (a0 == m_code[0]) && (a1 == m_code[1]) && (a2 == m_code[2]);
        exp_err  = 1'b0;
        exp_lock = 1'b0;
        if (ok) begin
            m_fail = 0;
            m_open = 1'b1;
        end else begin
            m_fail++;
            if (m_fail == P_MAX_FAIL) begin
                exp_lock = 1'b1;
                m_fail   = 0;
            end else begin
                exp_err = 1'b1;
            end
        end
        tick();
        check("eval_unlocked", 32'(unlocked), 32'(ok));
        check("eval_err", 32'(err), 32'(exp_err));
        check("eval_alarm", 32'(alarm), 32'(exp_lock));
        check("eval_idx", 32'(idx), 32'd0);
        check("clr_pulses", 32'(n_clr - c0), 32'd3);
        $display("attempt %0d %0d %0d -> open=%0d err=%0d lock=%0d", a0, a1, a2, ok, exp_err, exp_lock);
        if (exp_err) begin
            tick();
            check("err_one_cycle", 32'(err), 32'd0);
        end
        if (exp_lock) lockout_phase();
    endtask

    task automatic program_code(input int v0, input int v1, input int v2);
        prog = 1'b1;
        enter_value(v0, 1'b0);
        prog = 1'b0;
        check("prog_unlocked", 32'(unlocked), 32'd1);
        close = 1'b1;
        tick();
        close = 1'b0;
        check("prog_close_ignored", 32'(unlocked), 32'd1);
        enter_value(v1, 1'b0);
        enter_value(v2, 1'b0);
        check("prog_done_unlocked", 32'(unlocked), 32'd1);
        check("prog_done_idx", 32'(idx), 32'd0);
        m_code[0] = v0;
        m_code[1] = v1;
        m_code[2] = v2;
        $display("program %0d %0d %0d", v0, v1, v2);
    endtask

    task automatic close_lock();
        close = 1'b1;
        tick();
        close = 1'b0;
        check("close_unlocked", 32'(unlocked), 32'd0);
        m_open = 1'b0;
        $display("close");
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_up"},       32'(up),       32'd1);
        check({tag, "_cnten1"},   32'(cnten1),   32'd1);
        check({tag, "_cnten2"},   32'(cnten2),   32'd0);
        check({tag, "_clrCount"}, 32'(clrCount), 32'd0);
        check({tag, "_unlocked"}, 32'(unlocked), 32'd0);
        check({tag, "_err"},      32'(err),      32'd0);
        check({tag, "_alarm"},    32'(alarm),    32'd0);
        check({tag, "_idx"},      32'(idx),      32'd0);
    endtask

    initial begin
        int c;
        m_code[0] = 12;
        m_code[1] = 7;
        m_code[2] = 25;
        m_fail    = 0;
        m_open    = 1'b0;

        rst = 1'b1;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Wrap-around: 00 down -> 31, then back up -> 00.
        step = 1'b1;
        dir  = 1'b0;
        tick();
        step = 1'b0;
        check("wrap_up_dir", 32'(up), 32'd0);
        check("wrap_hold_low", 32'(cnten1), 32'd0);
        tick();
        check("wrap_hold_one_cycle", 32'(cnten1), 32'd1);
        check("wrap_down", 32'(dial), 32'd31);
        step = 1'b1;
        dir  = 1'b1;
        tick();
        step = 1'b0;
        tick();
        check("wrap_up", 32'(dial), 32'd0);
        $display("wrap test done");

        // Correct code, with steps coinciding with every enter.
        attempt(12, 7, 25, 1'b1);

        // enter without prog while open does nothing.
        c = n_clr;
        dial_to(9);
        enter = 1'b1;
        tick();
        enter = 1'b0;
        repeat (3) tick();
        check("open_enter_ignored_clr", 32'(n_clr - c), 32'd0);
        check("open_enter_ignored_unl", 32'(unlocked), 32'd1);
        close_lock();

        attempt(12, 7, 24, 1'b0);
        attempt(1, 2, 3, 1'b0);
        attempt(5, 5, 5, 1'b0);
        attempt(12, 7, 25, 1'b0);

        program_code(3, 3, 3);
        close_lock();
        attempt(3, 3, 3, 1'b0);
        close_lock();
        attempt(12, 7, 25, 1'b0);

        for (int it = 0; it < 8; it++) begin
            if (!m_open) begin
                if ($urandom_range(0, 1) == 1)
                    attempt(m_code[0], m_code[1], m_code[2], 1'($urandom_range(0, 1)));
                else
                    attempt(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                            int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            end else begin
                if ($urandom_range(0, 1) == 1)
                    program_code(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                                 int'($urandom_range(0, 31)));
                close_lock();
            end
        end

        // Reset in the middle of reprogramming.
        if (m_open) close_lock();
        attempt(m_code[0], m_code[1], m_code[2], 1'b0);
        prog = 1'b1;
        enter_value(int'($urandom_range(0, 31)), 1'b0);
        prog = 1'b0;
        enter_value(int'($urandom_range(0, 31)), 1'b0);
        rst = 1'b1;
        #1;
        check_reset_outputs("midprog_rst");
        check("midprog_rst_dial", 32'(dial), 32'd0);
        tick();
        rst       = 1'b0;
        m_code[0] = 12;
        m_code[1] = 7;
        m_code[2] = 25;
        m_fail    = 0;
        m_open    = 1'b0;
        $display("reset during programming");
        tick();
        attempt(12, 7, 25, 1'b0);
        close_lock();

        check("clr_never_with_step", 32'(n_overlap), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sejf_ctrl.md
# sejf_ctrl

Combination-lock controller for the safe. Turns user step/enter buttons into dial moves on the two-digit BCD dial counter (positions 00–31, wrapping), captures three dial values, and compares them against a stored code. Drives unlock, error and alarm indication, and enforces a lockout after repeated failures. Sits between the debounced button logic and the dial counter / display.

## Interface
- CODE0, 5'd12 — first code value (0–31, binary) loaded at reset
- CODE1, 5'd7 — second code value
- CODE2, 5'd25 — third code value
- MAX_FAIL, 3 — consecutive wrong entries that trigger lockout (1–7)
- LOCK_CYC, 1000 — lockout length in clk cycles (≥2)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- step  in  1  single-cycle pulse: move dial one position
- dir  in  1  step direction, 1 = up, 0 = down; sampled with step
- enter  in  1  single-cycle pulse: accept current dial value
- close  in  1  single-cycle pulse: relock while open
- prog  in  1  level: with enter while open, reprogram code
- bcd0  in  4  dial counter units digit
- bcd1  in  4  dial counter tens digit
- up  out  1  counter direction
- cnten1  out  1  counter step hold, active-low
- cnten2  out  1  counter freeze, active-high (counter counts only when both enables are 0)
- clrCount  out  1  counter clear, one-cycle pulse
- unlocked  out  1  lock open
- err  out  1  one-cycle pulse on wrong combination
- alarm  out  1  high for the whole lockout
- idx  out  2  index of the value being entered (0–2), for the display

## Operation
- Reset values: up=1, cnten1=1, cnten2=0, clrCount=0, unlocked=0, err=0, alarm=0, idx=0, fail_cnt=0, code registers = CODE0..2, state ENTRY. All outputs are registered.
- Dial value = bcd1*10+bcd0, 5-bit binary.
- ENTRY:
  - step → cnten1=0 for exactly one cycle, up=dir.
  - enter → CAPT; enter wins over a simultaneous step, and that step is dropped.
- CAPT (1 cycle): latch the dial value. ENTRY mode: OR a sticky mismatch flag with (value != code[idx]). PROG mode: write the value into code[idx]. Next state CLR.
- CLR (1 cycle): clrCount=1, cnten1=1. If idx=2: idx←0 and go to EVAL (ENTRY mode) or OPEN (PROG mode). Otherwise idx++ and return to the originating mode.
- EVAL (1 cycle), clears the mismatch flag:
  - No mismatch → OPEN, fail_cnt←0.
  - Mismatch, fail_cnt+1 < MAX_FAIL → err=1 pulse, fail_cnt++, ENTRY.
  - Mismatch, fail_cnt+1 = MAX_FAIL → LOCKOUT, timer←LOCK_CYC-1.
- OPEN: unlocked=1.
  - step operates the dial as in ENTRY.
  - close → ENTRY.
  - enter with prog=1 → PROG mode, handled like ENTRY; the first accepted value is captured into code[0].
  - enter with prog=0 is ignored.
  - close wins over enter.
- PROG: unlocked stays 1; close is ignored until all three values are written.
- LOCKOUT: alarm=1, cnten2=1 (dial frozen), all buttons ignored. When the timer reaches 0: clrCount pulse, fail_cnt←0, alarm←0, ENTRY.
- Button pulses arriving in CAPT, CLR or EVAL are dropped (no queueing).

## Timing
- step accepted at edge N → cnten1 low during cycle N+1 → new dial value visible from N+2.
- enter accepted at N → CAPT at N+1. A step at N-1 has therefore landed before capture.
- Third enter at N → EVAL at N+3 → unlocked or err at N+4.
- clrCount is never asserted in a cycle with cnten1=0.
- Lockout lasts exactly LOCK_CYC cycles of alarm=1.
- Asserting rst mid-entry or mid-program restores the parameter code and abandons the partial entry.

## Structure
- Package sejf_pkg holds:
  - the state enum (ENTRY, CAPT, CLR, EVAL, OPEN, PROG, LOCKOUT);
  - the mode flag;
  - CODE_W=5;
  - function bcd_to_bin(bcd1, bcd0).
- Sub-module sejf_lock_timer: loadable down-counter with a done flag.

## Test plan
- Dial to 12, enter; dial to 07, enter; dial to 25, enter → unlocked=1 at the 4th cycle after the last enter; clrCount pulsed 3×.
- Enter 12, 07, 24 → err pulses once, unlocked stays 0, idx=0, fail_cnt=1.
- Three wrong combinations (MAX_FAIL=3) → alarm=1 for exactly LOCK_CYC cycles, cnten2=1, steps ignored; afterwards dial=00 and the correct code opens.
- Open, prog=1, enter 03, 03, 03, close; then enter 03, 03, 03 → opens; old code 12, 07, 25 → err.
- At dial 00, step with dir=0 → dial 31; step and enter in the same cycle → value captured, no step issued.
- rst during PROG after 2 values → code reverts to 12, 07, 25, all outputs at reset values.
